// File: rtl/block_mem_ctrl.sv
// rtl/block_mem_ctrl.sv - 256-bit block backing-store controller with fixed per-access latency
// Serves one optional write-back followed by one optional instruction/data line fetch per request.
module block_mem_ctrl #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blockread,
    input  logic         blockwrite,
    input  logic [31:0]  instraddr,
    input  logic [31:0]  readaddr,
    input  logic [31:0]  writeaddr,
    input  logic [255:0] writeblock,
    output logic [255:0] instrblock,
    output logic [255:0] readblock,
    output logic         memready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_RD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            memready_q, memready_d;
    logic [255:0]    instr_q, instr_d;
    logic [255:0]    read_q, read_d;
    logic            rd_pend_q, rd_pend_d;
    logic [AW-1:0]   iaddr_q, iaddr_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [255:0]    wblock_q, wblock_d;
    logic            mem_we;

    logic [255:0]    mem_q [DEPTH];

    // Upper address bits are ignored so that addresses wrap onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instraddr[31:AW], readaddr[31:AW], writeaddr[31:AW]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        memready_d = memready_q;
        instr_d    = instr_q;
        read_d     = read_q;
        rd_pend_d  = rd_pend_q;
        iaddr_d    = iaddr_q;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        wblock_d   = wblock_q;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (blockread || blockwrite) begin
                    iaddr_d    = instraddr[AW-1:0];
                    raddr_d    = readaddr[AW-1:0];
                    waddr_d    = writeaddr[AW-1:0];
                    wblock_d   = writeblock;
                    rd_pend_d  = blockread;
                    memready_d = 1'b0;
                    cnt_d      = LAT_M1;
                    state_d    = blockwrite ? S_WB : S_RD;
                end
            end
            S_WB: begin
                if (cnt_q == '0) begin
                    mem_we = 1'b1;
                    if (rd_pend_q) begin
                        state_d = S_RD;
                        cnt_d   = LAT_M1;
                    end else begin
                        state_d    = S_IDLE;
                        memready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    instr_d    = mem_q[iaddr_q];
                    read_d     = mem_q[raddr_q];
                    memready_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            memready_q <= 1'b1;
            instr_q    <= '0;
            read_q     <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            memready_q <= memready_d;
            instr_q    <= instr_d;
            read_q     <= read_d;
            rd_pend_q  <= rd_pend_d;
        end
        iaddr_q  <= iaddr_d;
        raddr_q  <= raddr_d;
        waddr_q  <= waddr_d;
        wblock_q <= wblock_d;
    end

    // A reset landing on the commit edge discards the pending write-back.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[waddr_q] <= wblock_q;
        end
    end

    assign instrblock = instr_q;
    assign readblock  = read_q;
    assign memready   = memready_q;

endmodule

// File: tb/tb_block_mem_ctrl.sv
// tb/tb_block_mem_ctrl.sv - randomized self-checking bench for block_mem_ctrl
// Reference model: plain line array updated write-first per request.
module tb_block_mem_ctrl;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int NLINE = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         blockread, blockwrite;
    logic [31:0]  instraddr, readaddr, writeaddr;
    logic [255:0] writeblock;
    logic [255:0] instrblock, readblock;
    logic         memready;

    logic [255:0] ref_mem [DEPTH];
    logic [255:0] exp_i, exp_r;
    int           n_vec = 0;
    int           n_err = 0;

    block_mem_ctrl #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .blockread  (blockread),
        .blockwrite (blockwrite),
        .instraddr  (instraddr),
        .readaddr   (readaddr),
        .writeaddr  (writeaddr),
        .writeblock (writeblock),
        .instrblock (instrblock),
        .readblock  (readblock),
        .memready   (memready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] wrap_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        return (a & ~(DEPTH - 1)) | idx;
    endfunction

    task automatic do_req(input string tag, input bit br, input bit bw,
                          input logic [31:0] ia, input logic [31:0] ra, input logic [31:0] wa,
                          input logic [255:0] wd, input bit junk);
        int n;
        int lat;
        lat = (br && bw) ? 2 * LAT : LAT;
        @(negedge clk);
        blockread  = br;
        blockwrite = bw;
        instraddr  = ia;
        readaddr   = ra;
        writeaddr  = wa;
        writeblock = wd;
        @(posedge clk);
        #1;
        if (bw) ref_mem[wa % DEPTH] = wd;
        if (br) begin
            exp_i = ref_mem[ia % DEPTH];
            exp_r = ref_mem[ra % DEPTH];
        end
        check({tag, "_busy"}, memready, 0);
        n = 0;
        while (!memready && n < 100) begin
            @(negedge clk);
            if (junk) begin
                blockread  = 1'b1;
                blockwrite = 1'b1;
                instraddr  = $urandom;
                readaddr   = $urandom;
                writeaddr  = $urandom;
                writeblock = rand_line();
            end else begin
                blockread  = 1'b0;
                blockwrite = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        blockread  = 1'b0;
        blockwrite = 1'b0;
        check({tag, "_lat"}, n, lat);
        check({tag, "_instr"}, instrblock, exp_i);
        check({tag, "_read"}, readblock, exp_r);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] val_a, val_b, val_c, val_d, old7;
        bit br, bw;
        reset      = 1'b1;
        blockread  = 1'b0;
        blockwrite = 1'b0;
        instraddr  = '0;
        readaddr   = '0;
        writeaddr  = '0;
        writeblock = '0;
        exp_i      = '0;
        exp_r      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", memready, 1);
        check("rst_instr", instrblock, 0);
        check("rst_read", readblock, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NLINE; i++) begin
            do_req("init", 1'b0, 1'b1, 0, 0, i, rand_line(), 1'b0);
        end
        val_a = rand_line();
        val_b = rand_line();
        do_req("pre_a", 1'b0, 1'b1, 0, 0, 5, val_a, 1'b0);
        do_req("pre_b", 1'b0, 1'b1, 0, 0, 9, val_b, 1'b0);

        do_req("t1", 1'b1, 1'b0, 5, 9, 0, '0, 1'b0);
        check("t1_a", instrblock, val_a);
        check("t1_b", readblock, val_b);

        val_c = rand_line();
        do_req("t2", 1'b1, 1'b1, 5, 9, 9, val_c, 1'b0);
        check("t2_c", readblock, val_c);

        val_d = rand_line();
        do_req("t3w", 1'b0, 1'b1, 1, 2, 3, val_d, 1'b0);
        do_req("t3r", 1'b1, 1'b0, 3, 3, 0, '0, 1'b0);
        check("t3_d", readblock, val_d);

        do_req("t4", 1'b1, 1'b0, 3 * DEPTH + 9, DEPTH + 5, 0, '0, 1'b0);
        check("t4_wrap", readblock, val_a);

        do_req("t5", 1'b1, 1'b1, 4, 6, 8, rand_line(), 1'b1);

        old7 = ref_mem[7];
        @(negedge clk);
        blockwrite = 1'b1;
        writeaddr  = 7;
        writeblock = ~old7;
        @(posedge clk);
        #1;
        blockwrite = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ready", memready, 1);
        check("t6_instr", instrblock, 0);
        exp_i = '0;
        exp_r = '0;
        @(negedge clk);
        reset = 1'b0;
        do_req("t6r", 1'b1, 1'b0, 7, 7, 0, '0, 1'b0);
        check("t6_keep", readblock, old7);

        for (int k = 0; k < 150; k++) begin
            br = $urandom_range(0, 1);
            bw = $urandom_range(0, 1);
            if (!br && !bw) br = 1'b1;
            do_req("rnd", br, bw,
                   wrap_addr($urandom_range(0, NLINE - 1)),
                   wrap_addr($urandom_range(0, NLINE - 1)),
                   wrap_addr($urandom_range(0, NLINE - 1)),
                   rand_line(), bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
